// File: rtl/shift_button_conditioner.sv
// Conditions two raw push-buttons into mutually exclusive single-cycle shift pulses:
// 2-flop sync, tick-based debounce, press detect, hold-to-repeat FSM and an arbiter.
module shift_button_conditioner #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_PERIOD  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_left,
  input  logic btn_right,
  output logic shift_left,
  output logic shift_right,
  output logic held
);

  localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] C_LAST      = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PERIOD_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic [RW-1:0] R_SAT       = RW'(RMAX);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  // Index 0 is the left button, index 1 the right button.
  logic [1:0] raw;
  logic [1:0] stable;
  logic [1:0] stable_next;
  logic [1:0] req;
  logic       grant_left;
  logic       grant_right;

  assign raw = {btn_right, btn_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1;
      logic          sync2;
      logic          s_reg;
      logic          s_next;
      logic [CW-1:0] c_reg;
      logic [CW-1:0] c_next;
      state_t        st_reg;
      state_t        st_next;
      logic [RW-1:0] r_reg;
      logic [RW-1:0] r_next;
      logic          req_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1  <= 1'b0;
          sync2  <= 1'b0;
          s_reg  <= 1'b0;
          c_reg  <= '0;
          st_reg <= IDLE;
          r_reg  <= '0;
        end else begin
          sync1  <= raw[gi];
          sync2  <= sync1;
          s_reg  <= s_next;
          c_reg  <= c_next;
          st_reg <= st_next;
          r_reg  <= r_next;
        end
      end

      // Any cycle of agreement discards partial progress, even between ticks.
      always_comb begin
        s_next = s_reg;
        c_next = c_reg;
        if (sync2 == s_reg) begin
          c_next = '0;
        end else if (tick) begin
          if (c_reg >= C_LAST) begin
            s_next = ~s_reg;
            c_next = '0;
          end else begin
            c_next = c_reg + 1'b1;
          end
        end
      end

      always_comb begin
        st_next = st_reg;
        r_next  = r_reg;
        req_c   = 1'b0;
        case (st_reg)
          IDLE: begin
            if (s_reg) begin
              st_next = FIRST;
              r_next  = '0;
              req_c   = 1'b1;
            end
          end
          FIRST: begin
            if (!s_reg) begin
              st_next = IDLE;
            end else if ((REPEAT_DELAY != 0) && tick) begin
              if (r_reg == DELAY_LAST) begin
                st_next = REPEAT;
                r_next  = '0;
                req_c   = 1'b1;
              end else if (r_reg != R_SAT) begin
                r_next = r_reg + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!s_reg) begin
              st_next = IDLE;
            end else if (tick) begin
              if (r_reg == PERIOD_LAST) begin
                r_next = '0;
                req_c  = 1'b1;
              end else if (r_reg != R_SAT) begin
                r_next = r_reg + 1'b1;
              end
            end
          end
          default: st_next = IDLE;
        endcase
      end

      assign stable[gi]      = s_reg;
      assign stable_next[gi] = s_next;
      assign req[gi]         = req_c;
    end
  endgenerate

  // A request is dropped outright whenever the opposite button is debounced-high.
  assign grant_left  = req[0] & ~stable[1];
  assign grant_right = req[1] & ~stable[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
      held        <= 1'b0;
    end else begin
      shift_left  <= grant_left;
      shift_right <= grant_right;
      held        <= |stable_next;
    end
  end

endmodule

// File: tb/tb_shift_button_conditioner.sv
// Directed bench: instance a uses default parameters (no repeat), instance b uses
// REPEAT_DELAY=10 / REPEAT_PERIOD=4. Pulse cycle indices count edges from the first sampling edge.
module tb_shift_button_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn_left;
  logic btn_right;
  logic a_sl, a_sr, a_held;
  logic b_sl, b_sr, b_held;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int both_hi = 0;
  int a_held_seen = 0;
  bit slow_tick = 1'b0;
  int qal[$];
  int qar[$];
  int qbl[$];
  int qbr[$];

  always #5 clk = ~clk;

  shift_button_conditioner dut_a (
    .clk(clk), .rst(rst), .tick(tick), .btn_left(btn_left), .btn_right(btn_right),
    .shift_left(a_sl), .shift_right(a_sr), .held(a_held)
  );

  shift_button_conditioner #(
    .DEBOUNCE_TICKS(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .btn_left(btn_left), .btn_right(btn_right),
    .shift_left(b_sl), .shift_right(b_sr), .held(b_held)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-20s observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int qat(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic clear();
    qal.delete();
    qar.delete();
    qbl.delete();
    qbr.delete();
    a_held_seen = 0;
    cyc = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (a_sl) qal.push_back(cyc);
      if (a_sr) qar.push_back(cyc);
      if (b_sl) qbl.push_back(cyc);
      if (b_sr) qbr.push_back(cyc);
      if ((a_sl && a_sr) || (b_sl && b_sr)) both_hi++;
      if (a_held) a_held_seen++;
      cyc++;
      tick = slow_tick ? ((cyc % 4) == 3) : 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b1;
    btn_left = 1'b1;
    btn_right = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_shift_left", int'(a_sl), 0);
    check("rst_a_held", int'(a_held), 0);
    check("rst_b_held", int'(b_held), 0);

    // 1: button already high when reset releases
    rst = 1'b0;
    clear();
    run(20);
    check("s1_left_count", qal.size(), 1);
    check("s1_left_at", qat(qal, 0), 6);
    check("s1_right_count", qar.size(), 0);
    check("s1_held", int'(a_held), 1);
    btn_left = 1'b0;
    run(12);
    check("s1_release_held", int'(a_held), 0);

    // 2: short glitches on right
    clear();
    btn_right = 1'b1; run(3);
    btn_right = 1'b0; run(1);
    btn_right = 1'b1; run(3);
    btn_right = 1'b0; run(12);
    check("s2_right_count", qar.size(), 0);
    check("s2_held_seen", a_held_seen, 0);

    // 3: both buttons together
    clear();
    btn_left = 1'b1;
    btn_right = 1'b1;
    run(20);
    check("s3_a_left", qal.size(), 0);
    check("s3_a_right", qar.size(), 0);
    check("s3_b_left", qbl.size(), 0);
    check("s3_b_right", qbr.size(), 0);
    check("s3_held", int'(a_held), 1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    run(12);

    // 4: auto-repeat on instance b
    clear();
    btn_left = 1'b1; run(40);
    btn_left = 1'b0; run(20);
    check("s4_count", qbl.size(), 9);
    check("s4_first", qat(qbl, 0), 6);
    check("s4_second", qat(qbl, 1), 16);
    check("s4_third", qat(qbl, 2), 20);
    check("s4_last", qat(qbl, 8), 44);
    check("s4_right", qbr.size(), 0);

    // 5a: slow tick, clean press
    clear();
    slow_tick = 1'b1;
    tick = 1'b0;
    btn_right = 1'b1;
    run(40);
    check("s5_count", qar.size(), 1);
    check("s5_at", qat(qar, 0), 16);
    btn_right = 1'b0;
    slow_tick = 1'b0;
    tick = 1'b1;
    run(12);

    // 5b: one-cycle dropout between ticks discards three accumulated ticks
    clear();
    slow_tick = 1'b1;
    tick = 1'b0;
    btn_right = 1'b1; run(12);
    btn_right = 1'b0; run(1);
    btn_right = 1'b1; run(30);
    check("s5b_count", qar.size(), 1);
    check("s5b_at", qat(qar, 0), 28);
    check("s5b_held", int'(a_held), 1);
    btn_right = 1'b0;
    slow_tick = 1'b0;
    tick = 1'b1;
    run(12);

    // 6: right press suppresses left repeats on instance b
    clear();
    btn_left = 1'b1;  run(22);
    btn_right = 1'b1; run(18);
    btn_right = 1'b0; run(20);
    btn_left = 1'b0;  run(20);
    check("s6_count", qbl.size(), 9);
    check("s6_pre_right", qat(qbl, 3), 24);
    check("s6_resume", qat(qbl, 4), 48);
    check("s6_last", qat(qbl, 8), 64);
    check("s6_right", qbr.size(), 0);

    // 7: asynchronous reset while a pulse is high, button kept pressed
    clear();
    btn_left = 1'b1;
    run(7);
    check("s7_pulse_at", qat(qal, 0), 6);
    check("s7_pulse_high", int'(a_sl), 1);
    rst = 1'b1;
    #1;
    check("s7_async_left", int'(a_sl), 0);
    check("s7_async_held", int'(a_held), 0);
    check("s7_async_b_held", int'(b_held), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear();
    run(12);
    check("s7_fresh_count", qal.size(), 1);
    check("s7_fresh_at", qat(qal, 0), 6);
    btn_left = 1'b0;
    run(12);

    check("never_both", both_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
